sobel_stream_master: RTL

//  Stream master at the opposite end of the SobelFilter p2p ports.
//  - Fetches a frame of 24-bit RGB pixels from a sync source RAM and drives the filter rgb input stream.
//  - Collects the filter's three 8-bit result streams (r,g,b) and writes packed {r,g,b} words to a result RAM.
//  - Sits between the frame memories and the SobelFilter instance; o_done flags frame completion.

---
 rtl/sobel_stream_pkg.sv | 25 ++
 rtl/sobel_skid2.sv | 53 +++++
 rtl/sobel_stream_master.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_pkg.sv
// ============================================================================
// Module : sobel_stream_pkg
// Brief  : Shared types and helpers for the Sobel stream master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sobel_stream_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [7:0]  pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned npix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_skid2.sv
// ============================================================================
// Module : sobel_skid2
// Brief  : Two-entry FIFO absorbing source RAM read latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sobel_skid2 import sobel_stream_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  rgb_t       din,
    output logic [1:0] occ,
    output rgb_t       head
);

    rgb_t       entry0;
    rgb_t       entry1;
    logic       pop_ok;
    logic [1:0] occ_after_pop;

    assign pop_ok        = pop & (occ != 2'd0);
    assign occ_after_pop = occ - {1'b0, pop_ok};
    assign head          = entry0;

    // A push lands behind whatever survives this cycle's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (clr) begin
            occ <= 2'd0;
        end else begin
            if (pop_ok) begin
                entry0 <= entry1;
            end
            if (push) begin
                if (occ_after_pop == 2'd0) begin
                    entry0 <= din;
                end else begin
                    entry1 <= din;
                end
            end
            occ <= occ_after_pop + {1'b0, push};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sobel_stream_master.sv
// ============================================================================
// Module : sobel_stream_master
// Brief  : Feeds a frame from source RAM to the Sobel filter and packs its
//          r/g/b result streams into result RAM words.
//          Optional SOBEL_STREAM_PERF_EN adds cycle/stall counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sobel_stream_master import sobel_stream_pkg::*; #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_done,
    output logic              o_src_re,
    output logic [ADDR_W-1:0] o_src_addr,
    input  rgb_t              i_src_data,
    output logic              o_rgb_vld,
    output rgb_t              o_rgb_data,
    input  logic              i_rgb_busy,
    input  logic              i_result_r_vld,
    input  pix_t              i_result_r_data,
    output logic              o_result_r_busy,
    input  logic              i_result_g_vld,
    input  pix_t              i_result_g_data,
    output logic              o_result_g_busy,
    input  logic              i_result_b_vld,
    input  pix_t              i_result_b_data,
    output logic              o_result_b_busy,
    output logic              o_res_we,
    output logic [ADDR_W-1:0] o_res_addr,
    output rgb_t              o_res_data
`ifdef SOBEL_STREAM_PERF_EN
    ,
    output logic [31:0]       o_perf_cycles,
    output logic [31:0]       o_perf_stalls
`endif
);

    localparam int               CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(npix(IMG_W, IMG_H));

    state_e           state;
    state_e           state_nxt;
    logic             start_ok;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             rd_pend;
    logic             src_re;
    logic             pop;
    logic [1:0]       skid_occ;
    logic [2:0]       eff_occ;
    rgb_t             skid_head;
    logic [2:0]       full;
    logic [2:0]       busy;
    logic [2:0]       load;
    logic             all_full;
    logic             res_we;
    pix_t             hold_r;
    pix_t             hold_g;
    pix_t             hold_b;

    assign start_ok  = i_start & (state != RUN);
    assign o_rgb_vld = (skid_occ != 2'd0);
    assign pop       = o_rgb_vld & ~i_rgb_busy;
    assign all_full  = &full;
    assign load      = {i_result_r_vld, i_result_g_vld, i_result_b_vld} & ~busy;

    // Occupancy after this cycle's pop, so a drained slot can be refilled back-to-back.
    assign eff_occ = {1'b0, skid_occ} - {2'b00, pop} + {2'b00, rd_pend};

    sobel_skid2 u_skid (
        .clk   (i_clk),
        .rst_n (i_rst),
        .clr   (start_ok),
        .push  (rd_pend),
        .pop   (pop),
        .din   (i_src_data),
        .occ   (skid_occ),
        .head  (skid_head)
    );

    always_comb begin
        state_nxt = state;
        src_re    = 1'b0;
        res_we    = 1'b0;
        busy      = 3'b111;
        case (state)
            IDLE: begin
                if (i_start) state_nxt = RUN;
            end
            RUN: begin
                src_re = (rd_cnt < NPIX_C) && (eff_occ < 3'd2);
                busy   = full & {3{~all_full}};
                res_we = all_full;
                if (all_full && (wr_cnt == NPIX_C - 1'b1)) state_nxt = DONE;
            end
            DONE: begin
                if (i_start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            rd_pend <= 1'b0;
            full    <= 3'b000;
            hold_r  <= '0;
            hold_g  <= '0;
            hold_b  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                rd_pend <= 1'b0;
                full    <= 3'b000;
            end else begin
                rd_pend <= src_re;
                if (src_re) rd_cnt <= rd_cnt + 1'b1;
                if (res_we) wr_cnt <= wr_cnt + 1'b1;
                full <= load | (full & {3{~res_we}});
            end
            if (load[2]) hold_r <= i_result_r_data;
            if (load[1]) hold_g <= i_result_g_data;
            if (load[0]) hold_b <= i_result_b_data;
        end
    end

    assign o_done          = (state == DONE);
    assign o_src_re        = src_re;
    assign o_src_addr      = rd_cnt[ADDR_W-1:0];
    assign o_rgb_data      = skid_head;
    assign o_result_r_busy = busy[2];
    assign o_result_g_busy = busy[1];
    assign o_result_b_busy = busy[0];
    assign o_res_we        = res_we;
    assign o_res_addr      = wr_cnt[ADDR_W-1:0];
    assign o_res_data      = {hold_r, hold_g, hold_b};

`ifdef SOBEL_STREAM_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stalls;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if ((state == RUN) && (perf_cycles != 32'hFFFF_FFFF)) perf_cycles <= perf_cycles + 1'b1;
            if (o_rgb_vld && i_rgb_busy && (perf_stalls != 32'hFFFF_FFFF)) perf_stalls <= perf_stalls + 1'b1;
        end
    end

    assign o_perf_cycles = perf_cycles;
    assign o_perf_stalls = perf_stalls;
`endif

endmodule

`default_nettype wire
